// File: rtl/meteo_display_mux.sv
// Multi-channel 7-segment display engine: per-channel BCD snapshots, manual/auto channel select,
// registered segment outputs. Optional leading-zero blanking under METEO_LZ_BLANK_EN.

module meteo_seg7 (
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'b0111111;
        if (dash_i) begin
            seg_o = 7'b0111111;
        end else if (blank_i) begin
            seg_o = 7'b1111111;
        end else begin
            case (nib_i)
                4'd0:    seg_o = 7'b1000000;
                4'd1:    seg_o = 7'b1111001;
                4'd2:    seg_o = 7'b0100100;
                4'd3:    seg_o = 7'b0110000;
                4'd4:    seg_o = 7'b0011001;
                4'd5:    seg_o = 7'b0010010;
                4'd6:    seg_o = 7'b0000010;
                4'd7:    seg_o = 7'b1111000;
                4'd8:    seg_o = 7'b0000000;
                4'd9:    seg_o = 7'b0010000;
                default: seg_o = 7'b0111111;
            endcase
        end
    end
endmodule

module meteo_display_mux #(
    parameter int NCH   = 3,
    parameter int NDIG  = 6,
    parameter int DWELL = 100000000,
    parameter int CW    = 27
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [NCH*NDIG*4-1:0] Bcd_i,
    input  logic [NCH-1:0]        Valid_i,
    input  logic [NCH-1:0]        Sel_i,
    input  logic                  Auto_i,
    output logic [NDIG*7-1:0]     Dec_o,
    output logic [2:0]            Chan_o,
    output logic                  Stale_o
);
    localparam int DW = NDIG * 4;
    localparam int SW = NDIG * 7;

    logic [NCH-1:0][DW-1:0] snap_q, snap_d;
    logic [NCH-1:0]         cap_q, cap_d;
    logic [2:0]             chan_q, chan_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          dec_q, dec_d;
    logic [2:0]             chan_o_q, chan_o_d;
    logic                   stale_q, stale_d;

    logic [DW-1:0]          cur_snap;
    logic                   cur_cap;
    logic [NDIG-1:0]        blank;

    always_comb begin
        snap_d = snap_q;
        cap_d  = cap_q;
        for (int c = 0; c < NCH; c++) begin
            if (Valid_i[c]) begin
                snap_d[c] = Bcd_i[c*DW +: DW];
                cap_d[c]  = 1'b1;
            end
        end
    end

    // Manual mode keeps the dwell counter at 0 so a later switch to auto starts a full dwell.
    always_comb begin
        chan_d = chan_q;
        cnt_d  = '0;
        if (Auto_i) begin
            if (cnt_q == CW'(DWELL - 1)) begin
                cnt_d  = '0;
                chan_d = (chan_q == 3'(NCH - 1)) ? 3'd0 : chan_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (Sel_i[c]) chan_d = 3'(c);
            end
        end
    end

    always_comb begin
        cur_snap = '0;
        cur_cap  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (chan_q == 3'(c)) begin
                cur_snap = snap_q[c];
                cur_cap  = cap_q[c];
            end
        end
    end

    always_comb begin
        stale_d  = ~cur_cap;
        chan_o_d = chan_q;
    end

`ifdef METEO_LZ_BLANK_EN
    // A digit blanks only while every digit above it is a blanked zero; digit 0 always shows.
    always_comb begin
        logic run;
        blank = '0;
        run   = 1'b1;
        for (int d = NDIG - 1; d >= 1; d--) begin
            run      = run & (cur_snap[d*4 +: 4] == 4'd0);
            blank[d] = run & ~stale_d;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        meteo_seg7 u_seg (
            .nib_i   (cur_snap[d*4 +: 4]),
            .blank_i (blank[d]),
            .dash_i  (stale_d),
            .seg_o   (dec_d[d*7 +: 7])
        );
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            snap_q   <= '0;
            cap_q    <= '0;
            chan_q   <= '0;
            cnt_q    <= '0;
            dec_q    <= '1;
            chan_o_q <= '0;
            stale_q  <= 1'b1;
        end else begin
            snap_q   <= snap_d;
            cap_q    <= cap_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            chan_o_q <= chan_o_d;
            stale_q  <= stale_d;
        end
    end

    assign Dec_o   = dec_q;
    assign Chan_o  = chan_o_q;
    assign Stale_o = stale_q;
endmodule
